// File: rtl/kabeta_clk_pkg.sv
// Shared types and default timing for the PLL / domain reset sequencer.
// The output decode lives here so every user agrees on the per-state levels.
`timescale 1ns/1ps
package kabeta_clk_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    REL_IO,
    RUN
  } seq_state_t;

  localparam int RETRY_MAX = 15;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PLL_RESET_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RELEASE_GAP_CYCLES = 8;
  localparam int DEF_CNT_W = 17;

  typedef struct packed {
    logic pll_rst;
    logic io_rst;
    logic sys_rst;
    logic ready;
  } seq_out_t;

  function automatic seq_out_t decode_outs(seq_state_t s);
    seq_out_t o;
    o.pll_rst = (s == PLL_RST);
    o.io_rst = !((s == REL_IO) || (s == RUN));
    o.sys_rst = (s != RUN);
    o.ready = (s == RUN);
    return o;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level.
// Clears to 0 so a stale lock never leaks out of reset.
`timescale 1ns/1ps
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, debounced lock wait and ordered IO/Sys domain reset release.
// Outputs are registered from the next state so they move on the transition edge.
`timescale 1ns/1ps
module pll_reset_sequencer
  import kabeta_clk_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PLL_RESET_CYCLES = DEF_PLL_RESET_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RELEASE_GAP_CYCLES = DEF_RELEASE_GAP_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Locked,
  input  logic       Relock_Req,
  output logic       PLL_Reset,
  output logic       IO_Reset,
  output logic       Sys_Reset,
  output logic       Ready,
  output logic       Lock_Lost,
  output logic [3:0] Retry_Count
);

  seq_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] retry_n;
  logic lost_n;
  logic locked_s;
  logic cnt_zero;
  logic relock;
  logic timeout;
  seq_out_t outs_n;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(Clock),
    .rst(Reset),
    .d  (Locked),
    .q  (locked_s)
  );

  // STABLE loads the full count: entry edge plus that many confirmations
  function automatic logic [CNT_W-1:0] load_for(seq_state_t s);
    case (s)
      PLL_RST:   return CNT_W'(PLL_RESET_CYCLES - 1);
      WAIT_LOCK: return CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
      STABLE:    return CNT_W'(LOCK_STABLE_CYCLES);
      REL_IO:    return CNT_W'(RELEASE_GAP_CYCLES - 1);
      default:   return '0;
    endcase
  endfunction

  assign cnt_zero = (cnt == '0);
  assign relock = Relock_Req && (state != PLL_RST);
  assign timeout = (state == WAIT_LOCK) && !relock
                && !locked_s && cnt_zero;

  always_comb begin
    state_n = state;
    cnt_n = cnt_zero ? cnt : cnt - CNT_W'(1);
    unique case (state)
      PLL_RST: begin
        if (cnt_zero) state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (relock) state_n = PLL_RST;
        else if (locked_s) state_n = STABLE;
        else if (cnt_zero) state_n = PLL_RST;
      end
      STABLE: begin
        if (relock) state_n = PLL_RST;
        else if (!locked_s) state_n = WAIT_LOCK;
        else if (cnt_zero) state_n = REL_IO;
      end
      REL_IO: begin
        if (relock) state_n = PLL_RST;
        else if (!locked_s) state_n = WAIT_LOCK;
        else if (cnt_zero) state_n = RUN;
      end
      RUN: begin
        if (relock) state_n = PLL_RST;
        else if (!locked_s) state_n = WAIT_LOCK;
      end
      default: state_n = PLL_RST;
    endcase
    if (state_n != state) cnt_n = load_for(state_n);
  end

  always_comb begin
    retry_n = Retry_Count;
    if (timeout && (Retry_Count != 4'(RETRY_MAX)))
      retry_n = Retry_Count + 4'd1;
  end

  // a lock drop seen in RUN outranks a same-cycle relock clear
  always_comb begin
    lost_n = Lock_Lost;
    if ((state == RUN) && !locked_s) lost_n = 1'b1;
    else if (relock) lost_n = 1'b0;
  end

  assign outs_n = decode_outs(state_n);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= PLL_RST;
      cnt <= CNT_W'(PLL_RESET_CYCLES - 1);
      Retry_Count <= '0;
      Lock_Lost <= 1'b0;
      PLL_Reset <= 1'b1;
      IO_Reset <= 1'b1;
      Sys_Reset <= 1'b1;
      Ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      Retry_Count <= retry_n;
      Lock_Lost <= lost_n;
      PLL_Reset <= outs_n.pll_rst;
      IO_Reset <= outs_n.io_rst;
      Sys_Reset <= outs_n.sys_rst;
      Ready <= outs_n.ready;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short cycle parameters.
// Edge numbers count rising edges since the last Reset release.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic locked;
  logic relock;
  logic pll_reset, io_reset, sys_reset, ready, lock_lost;
  logic [3:0] retry;
  logic [4:0] outs;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign outs = {pll_reset, io_reset, sys_reset, ready, lock_lost};

  pll_reset_sequencer #(
    .SYNC_STAGES(2),
    .PLL_RESET_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES(8),
    .RELEASE_GAP_CYCLES(3),
    .CNT_W(17)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .Locked(locked),
    .Relock_Req(relock),
    .PLL_Reset(pll_reset),
    .IO_Reset(io_reset),
    .Sys_Reset(sys_reset),
    .Ready(ready),
    .Lock_Lost(lock_lost),
    .Retry_Count(retry)
  );

  task automatic goto(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset(input logic lk);
    rst = 1'b1;
    relock = 1'b0;
    locked = lk;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_cmp++;
    if (outs !== 5'b11100) begin
      n_bad++;
      $display("FAIL reset_outs got %b want 11100", outs);
    end
    n_cmp++;
    if (retry !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_retry got %0d want 0", retry);
    end
    goto(3);
    n_cmp++;
    if (outs !== 5'b11100) begin
      n_bad++;
      $display("FAIL pll_pulse_end got %b want 11100", outs);
    end
    goto(4);
    n_cmp++;
    if (outs !== 5'b01100) begin
      n_bad++;
      $display("FAIL wait_lock_entry got %b want 01100", outs);
    end
  endtask

  task automatic test_release();
    goto(10);
    locked = 1'b1;
    goto(21);
    n_cmp++;
    if (outs !== 5'b01100) begin
      n_bad++;
      $display("FAIL pre_io_rel got %b want 01100", outs);
    end
    goto(22);
    n_cmp++;
    if (outs !== 5'b00100) begin
      n_bad++;
      $display("FAIL io_rel got %b want 00100", outs);
    end
    goto(24);
    n_cmp++;
    if (outs !== 5'b00100) begin
      n_bad++;
      $display("FAIL rel_gap got %b want 00100", outs);
    end
    goto(25);
    n_cmp++;
    if (outs !== 5'b00010) begin
      n_bad++;
      $display("FAIL run_entry got %b want 00010", outs);
    end
  endtask

  task automatic test_lock_loss();
    goto(30);
    locked = 1'b0;
    goto(32);
    n_cmp++;
    if (outs !== 5'b00010) begin
      n_bad++;
      $display("FAIL loss_sync_delay got %b want 00010", outs);
    end
    goto(33);
    n_cmp++;
    if (outs !== 5'b01101) begin
      n_bad++;
      $display("FAIL loss_seen got %b want 01101", outs);
    end
    goto(35);
    locked = 1'b1;
    goto(46);
    n_cmp++;
    if (outs !== 5'b01101) begin
      n_bad++;
      $display("FAIL relock_pre_io got %b want 01101", outs);
    end
    goto(47);
    n_cmp++;
    if (outs !== 5'b00101) begin
      n_bad++;
      $display("FAIL relock_io got %b want 00101", outs);
    end
    goto(50);
    n_cmp++;
    if (outs !== 5'b00011) begin
      n_bad++;
      $display("FAIL relock_run got %b want 00011", outs);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_r;
    do_reset(1'b0);
    for (int k = 1; k <= 17; k++) begin
      exp_r = (k > 15) ? 4'd15 : 4'(k);
      goto(36 * k - 1);
      n_cmp++;
      if (pll_reset !== 1'b0) begin
        n_bad++;
        $display("FAIL to_pre[%0d] got %b want 0", k, pll_reset);
      end
      goto(36 * k);
      n_cmp++;
      if (pll_reset !== 1'b1 || retry !== exp_r) begin
        n_bad++;
        $display("FAIL to_pulse[%0d] got %b/%0d want 1/%0d",
                 k, pll_reset, retry, exp_r);
      end
      goto(36 * k + 3);
      n_cmp++;
      if (pll_reset !== 1'b1) begin
        n_bad++;
        $display("FAIL to_hold[%0d] got %b want 1", k, pll_reset);
      end
      goto(36 * k + 4);
      n_cmp++;
      if (outs !== 5'b01100) begin
        n_bad++;
        $display("FAIL to_end[%0d] got %b want 01100", k, outs);
      end
    end
  endtask

  task automatic test_timeout_vs_lock();
    do_reset(1'b0);
    goto(33);
    locked = 1'b1;
    goto(36);
    n_cmp++;
    if (outs !== 5'b01100 || retry !== 4'd0) begin
      n_bad++;
      $display("FAIL tvl_edge got %b/%0d want 01100/0", outs, retry);
    end
    goto(44);
    n_cmp++;
    if (outs !== 5'b01100) begin
      n_bad++;
      $display("FAIL tvl_stable got %b want 01100", outs);
    end
    goto(45);
    n_cmp++;
    if (outs !== 5'b00100 || retry !== 4'd0) begin
      n_bad++;
      $display("FAIL tvl_io got %b/%0d want 00100/0", outs, retry);
    end
  endtask

  task automatic test_stable_glitch();
    do_reset(1'b0);
    goto(10);
    locked = 1'b1;
    goto(18);
    locked = 1'b0;
    goto(20);
    locked = 1'b1;
    for (int k = 11; k <= 31; k++) begin
      goto(k);
      n_cmp++;
      if (io_reset !== 1'b1) begin
        n_bad++;
        $display("FAIL glitch_io[%0d] got %b want 1", k, io_reset);
      end
    end
    goto(32);
    n_cmp++;
    if (outs !== 5'b00100) begin
      n_bad++;
      $display("FAIL glitch_rel got %b want 00100", outs);
    end
  endtask

  task automatic test_relock_collision();
    do_reset(1'b0);
    goto(10);
    locked = 1'b1;
    goto(30);
    locked = 1'b0;
    goto(32);
    relock = 1'b1;
    goto(33);
    relock = 1'b0;
    n_cmp++;
    if (outs !== 5'b11101) begin
      n_bad++;
      $display("FAIL coll_edge got %b want 11101", outs);
    end
    goto(36);
    n_cmp++;
    if (outs !== 5'b11101) begin
      n_bad++;
      $display("FAIL coll_hold got %b want 11101", outs);
    end
    goto(37);
    n_cmp++;
    if (outs !== 5'b01101) begin
      n_bad++;
      $display("FAIL coll_end got %b want 01101", outs);
    end
    goto(38);
    relock = 1'b1;
    goto(39);
    n_cmp++;
    if (outs !== 5'b11100) begin
      n_bad++;
      $display("FAIL relock_clear got %b want 11100", outs);
    end
    goto(42);
    relock = 1'b0;
    n_cmp++;
    if (outs !== 5'b11100) begin
      n_bad++;
      $display("FAIL relock_ignored got %b want 11100", outs);
    end
    goto(43);
    n_cmp++;
    if (outs !== 5'b01100 || retry !== 4'd0) begin
      n_bad++;
      $display("FAIL no_extend got %b/%0d want 01100/0", outs, retry);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    goto(15);
    n_cmp++;
    if (outs !== 5'b00100) begin
      n_bad++;
      $display("FAIL mid_rel_io got %b want 00100", outs);
    end
    #1;
    rst = 1'b1;
    #0.5;
    n_cmp++;
    if (outs !== 5'b11100 || retry !== 4'd0) begin
      n_bad++;
      $display("FAIL async_rst got %b/%0d want 11100/0", outs, retry);
    end
    #0.5;
    rst = 1'b0;
    cyc = 0;
    goto(3);
    n_cmp++;
    if (outs !== 5'b11100) begin
      n_bad++;
      $display("FAIL restart_pll got %b want 11100", outs);
    end
    goto(4);
    n_cmp++;
    if (outs !== 5'b01100) begin
      n_bad++;
      $display("FAIL restart_wait got %b want 01100", outs);
    end
    goto(13);
    n_cmp++;
    if (outs !== 5'b01100) begin
      n_bad++;
      $display("FAIL restart_stable got %b want 01100", outs);
    end
    goto(14);
    n_cmp++;
    if (outs !== 5'b00100) begin
      n_bad++;
      $display("FAIL restart_io got %b want 00100", outs);
    end
  endtask

  initial begin
    rst = 1'b1;
    locked = 1'b0;
    relock = 1'b0;
    test_reset();
    test_release();
    test_lock_loss();
    test_timeout();
    test_timeout_vs_lock();
    test_stable_glitch();
    test_relock_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
